// File: rtl/dma_desc_queue.sv
// Multi-channel DMA descriptor queue: per-channel descriptor FIFOs feeding a
// round-robin registered issue stage, outstanding tracking and a FWFT completion FIFO.
module dma_desc_queue #(
  parameter int  ADDR_WIDTH      = 16,
  parameter int  DESC_WIDTH      = 64,
  parameter int  NUM_CH          = 4,
  parameter int  FIFO_ADDR_WIDTH = 2,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int CH_WIDTH        = $clog2(NUM_CH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [NUM_CH-1:0]                      i_ch_enable,
  input  logic                                   i_desc_wr,
  input  logic [CH_WIDTH-1:0]                    i_desc_ch_sel,
  input  logic [7:0]                             i_desc_id,
  input  logic [DESC_WIDTH-1:0]                  i_desc_data,
  output logic                                   o_desc_wready,
  output logic                                   o_desc_valid,
  input  logic                                   i_desc_ready,
  output logic [CH_WIDTH-1:0]                    o_desc_ch_sel,
  output logic [7:0]                             o_desc_id,
  output logic [DESC_WIDTH-1:0]                  o_desc_data,
  input  logic                                   i_resp_wr,
  input  logic [CH_WIDTH-1:0]                    i_resp_ch_sel,
  input  logic [7:0]                             i_resp_desc_id,
  output logic                                   o_resp_wready,
  input  logic                                   i_resp_rd,
  output logic                                   o_resp_valid,
  output logic [CH_WIDTH-1:0]                    o_resp_ch_sel,
  output logic [7:0]                             o_resp_desc_id,
  output logic [NUM_CH*(FIFO_ADDR_WIDTH+1)-1:0]  o_ch_level,
  output logic                                   o_err_unexp_resp
);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam int EW    = 8 + DESC_WIDTH;
  localparam int RW    = CH_WIDTH + 8;

  if (NUM_CH < 2 || NUM_CH > 16 || ADDR_WIDTH < 1 || MAX_OUTSTANDING > 15) begin : g_param_check
    $error("dma_desc_queue: unsupported parameter set");
  end

  logic [EW-1:0]         r_mem   [NUM_CH][DEPTH];
  logic [LW-1:0]         r_wptr  [NUM_CH];
  logic [LW-1:0]         r_rptr  [NUM_CH];
  logic [3:0]            r_outst [NUM_CH];
  logic [CH_WIDTH-1:0]   r_last;
  logic                  r_desc_valid;
  logic [CH_WIDTH-1:0]   r_desc_ch;
  logic [7:0]            r_desc_id;
  logic [DESC_WIDTH-1:0] r_desc_data;
  logic [RW-1:0]         r_rmem  [DEPTH];
  logic [LW-1:0]         r_rwptr;
  logic [LW-1:0]         r_rrptr;
  logic                  r_err;

  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_elig;
  logic                  w_full_sel;
  logic                  w_outst_nz;
  logic                  w_found;
  logic [CH_WIDTH-1:0]   w_grant;
  logic [CH_WIDTH-1:0]   w_cand;
  logic [EW-1:0]         w_head;
  logic                  w_push;
  logic                  w_load;
  logic                  w_resp_full;
  logic                  w_resp_empty;
  logic                  w_resp_acc;
  logic                  w_resp_push;
  logic                  w_resp_pop;

  // Per-channel status plus lookups for the channels addressed by the push ports
  always_comb begin
    w_full_sel = 1'b1;
    w_outst_nz = 1'b0;
    o_ch_level = '0;
    w_empty    = '0;
    w_full     = '0;
    w_elig     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
      w_full[c]  = ((r_wptr[c] - r_rptr[c]) == LW'(DEPTH));
      w_elig[c]  = !w_empty[c] && i_ch_enable[c] && (r_outst[c] < 4'(MAX_OUTSTANDING));
      o_ch_level[c*LW +: LW] = r_wptr[c] - r_rptr[c];
      if (i_desc_ch_sel == CH_WIDTH'(c)) w_full_sel = w_full[c];
      if (i_resp_ch_sel == CH_WIDTH'(c)) w_outst_nz = (r_outst[c] != '0);
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last;
    w_cand  = r_last;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_cand = CH_WIDTH'((32'(r_last) + k) % NUM_CH);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_head        = r_mem[w_grant][r_rptr[w_grant][FIFO_ADDR_WIDTH-1:0]];
  assign o_desc_wready = enable & ~w_full_sel;
  assign w_push        = i_desc_wr & o_desc_wready;
  assign w_load        = enable & w_found & (~r_desc_valid | i_desc_ready);
  assign w_resp_full   = ((r_rwptr - r_rrptr) == LW'(DEPTH));
  assign w_resp_empty  = (r_rwptr == r_rrptr);
  assign o_resp_wready = enable & ~w_resp_full;
  assign w_resp_acc    = i_resp_wr & o_resp_wready;
  assign w_resp_push   = w_resp_acc & w_outst_nz;
  assign w_resp_pop    = i_resp_rd & ~w_resp_empty & enable;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[i_desc_ch_sel][r_wptr[i_desc_ch_sel][FIFO_ADDR_WIDTH-1:0]] <= {i_desc_id, i_desc_data};
    if (w_resp_push)
      r_rmem[r_rwptr[FIFO_ADDR_WIDTH-1:0]] <= {i_resp_ch_sel, i_resp_desc_id};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_outst[c] <= '0;
      end
      r_last       <= CH_WIDTH'(NUM_CH - 1);
      r_desc_valid <= 1'b0;
      r_desc_ch    <= '0;
      r_desc_id    <= '0;
      r_desc_data  <= '0;
      r_rwptr      <= '0;
      r_rrptr      <= '0;
      r_err        <= 1'b0;
    end else if (enable) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_push && i_desc_ch_sel == CH_WIDTH'(c)) r_wptr[c] <= r_wptr[c] + LW'(1);
        if (w_load && w_grant == CH_WIDTH'(c))       r_rptr[c] <= r_rptr[c] + LW'(1);
        // An issue and a completion on the same channel cancel out
        if ((w_load && w_grant == CH_WIDTH'(c)) && !(w_resp_push && i_resp_ch_sel == CH_WIDTH'(c)))
          r_outst[c] <= r_outst[c] + 4'd1;
        else if (!(w_load && w_grant == CH_WIDTH'(c)) && (w_resp_push && i_resp_ch_sel == CH_WIDTH'(c)))
          r_outst[c] <= r_outst[c] - 4'd1;
      end
      if (w_load) begin
        r_desc_valid             <= 1'b1;
        r_desc_ch                <= w_grant;
        {r_desc_id, r_desc_data} <= w_head;
        r_last                   <= w_grant;
      end else if (i_desc_ready) begin
        r_desc_valid <= 1'b0;
      end
      if (w_resp_push) r_rwptr <= r_rwptr + LW'(1);
      if (w_resp_pop)  r_rrptr <= r_rrptr + LW'(1);
      if (w_resp_acc && !w_outst_nz) r_err <= 1'b1;
    end
  end

  assign o_desc_valid     = r_desc_valid;
  assign o_desc_ch_sel    = r_desc_ch;
  assign o_desc_id        = r_desc_id;
  assign o_desc_data      = r_desc_data;
  assign o_resp_valid     = ~w_resp_empty;
  assign {o_resp_ch_sel, o_resp_desc_id} = w_resp_empty ? '0 : r_rmem[r_rrptr[FIFO_ADDR_WIDTH-1:0]];
  assign o_err_unexp_resp = r_err;

endmodule

// File: tb/tb_dma_desc_queue.sv
// Scoreboard bench for dma_desc_queue: expected issues/completions are queued as
// stimulus is driven and compared when the DUT hands them over.
module tb_dma_desc_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  i_ch_enable = 4'hF;
  logic        i_desc_wr = 1'b0;
  logic [1:0]  i_desc_ch_sel = '0;
  logic [7:0]  i_desc_id = '0;
  logic [63:0] i_desc_data = '0;
  logic        o_desc_wready;
  logic        o_desc_valid;
  logic        i_desc_ready = 1'b0;
  logic [1:0]  o_desc_ch_sel;
  logic [7:0]  o_desc_id;
  logic [63:0] o_desc_data;
  logic        i_resp_wr = 1'b0;
  logic [1:0]  i_resp_ch_sel = '0;
  logic [7:0]  i_resp_desc_id = '0;
  logic        o_resp_wready;
  logic        i_resp_rd = 1'b0;
  logic        o_resp_valid;
  logic [1:0]  o_resp_ch_sel;
  logic [7:0]  o_resp_desc_id;
  logic [11:0] o_ch_level;
  logic        o_err_unexp_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_iss[$];
  logic [9:0] exp_rsp[$];

  dma_desc_queue #(.ADDR_WIDTH(16), .DESC_WIDTH(64), .NUM_CH(4), .FIFO_ADDR_WIDTH(2), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .i_ch_enable(i_ch_enable),
    .i_desc_wr(i_desc_wr), .i_desc_ch_sel(i_desc_ch_sel), .i_desc_id(i_desc_id),
    .i_desc_data(i_desc_data), .o_desc_wready(o_desc_wready), .o_desc_valid(o_desc_valid),
    .i_desc_ready(i_desc_ready), .o_desc_ch_sel(o_desc_ch_sel), .o_desc_id(o_desc_id),
    .o_desc_data(o_desc_data), .i_resp_wr(i_resp_wr), .i_resp_ch_sel(i_resp_ch_sel),
    .i_resp_desc_id(i_resp_desc_id), .o_resp_wready(o_resp_wready), .i_resp_rd(i_resp_rd),
    .o_resp_valid(o_resp_valid), .o_resp_ch_sel(o_resp_ch_sel), .o_resp_desc_id(o_resp_desc_id),
    .o_ch_level(o_ch_level), .o_err_unexp_resp(o_err_unexp_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input logic [1:0] ch, input logic [7:0] id);
    return {24'hDA7A00, 6'd0, ch, 24'h0, id};
  endfunction

  function automatic logic [2:0] lvl(input int c);
    return o_ch_level[c*3 +: 3];
  endfunction

  // Handshakes complete on the following rising edge; compare them here
  always @(negedge clk) begin
    if (!reset && enable && o_desc_valid && i_desc_ready) begin
      if (exp_iss.size() == 0) check("issue_unexpected", {1'b1, o_desc_ch_sel, o_desc_id}, 64'd0);
      else begin
        logic [9:0] e;
        e = exp_iss.pop_front();
        check("issue_ch", o_desc_ch_sel, e[9:8]);
        check("issue_id", o_desc_id, e[7:0]);
        check("issue_data", o_desc_data, mkdata(e[9:8], e[7:0]));
      end
    end
    if (!reset && enable && o_resp_valid && i_resp_rd) begin
      if (exp_rsp.size() == 0) check("resp_unexpected", {1'b1, o_resp_ch_sel, o_resp_desc_id}, 64'd0);
      else begin
        logic [9:0] e;
        e = exp_rsp.pop_front();
        check("resp_ch", o_resp_ch_sel, e[9:8]);
        check("resp_id", o_resp_desc_id, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] id, input bit sb);
    i_desc_wr = 1'b1;
    i_desc_ch_sel = ch;
    i_desc_id = id;
    i_desc_data = mkdata(ch, id);
    #1;
    check("push_wready", o_desc_wready, 1'b1);
    if (sb) exp_iss.push_back({ch, id});
    tick();
    i_desc_wr = 1'b0;
  endtask

  task automatic resp(input logic [1:0] ch, input logic [7:0] id, input bit sb);
    i_resp_wr = 1'b1;
    i_resp_ch_sel = ch;
    i_resp_desc_id = id;
    if (sb) exp_rsp.push_back({ch, id});
    tick();
    i_resp_wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_iss.size() == 0 && exp_rsp.size() == 0) break;
      tick();
    end
    check("drain_issue", exp_iss.size(), 0);
    check("drain_resp", exp_rsp.size(), 0);
  endtask

  initial begin
    int cnt;
    tick();
    check("rst_valid", o_desc_valid, 1'b0);
    check("rst_level", o_ch_level, 12'd0);
    check("rst_err", o_err_unexp_resp, 1'b0);
    check("rst_desc", {o_desc_ch_sel, o_desc_id, o_desc_data}, '0);
    check("rst_resp", {o_resp_valid, o_resp_ch_sel, o_resp_desc_id}, '0);
    reset = 1'b0;
    tick();

    // Two-edge latency and hold while the engine is not ready
    push(2'd2, 8'h11, 1'b0);
    check("lat_valid_e1", o_desc_valid, 1'b0);
    check("lat_level_e1", lvl(2), 3'd1);
    tick();
    check("lat_valid_e2", o_desc_valid, 1'b1);
    check("lat_ch", o_desc_ch_sel, 2'd2);
    check("lat_id", o_desc_id, 8'h11);
    check("lat_level_e2", lvl(2), 3'd0);
    repeat (3) tick();
    check("hold_valid", o_desc_valid, 1'b1);
    check("hold_id", o_desc_id, 8'h11);
    // Global hold blocks every handshake
    enable = 1'b0;
    i_desc_ready = 1'b1;
    i_desc_wr = 1'b1;
    i_desc_ch_sel = 2'd0;
    i_desc_id = 8'h55;
    #1;
    check("dis_wready", o_desc_wready, 1'b0);
    check("dis_resp_wready", o_resp_wready, 1'b0);
    tick();
    tick();
    check("dis_valid", o_desc_valid, 1'b1);
    check("dis_level0", lvl(0), 3'd0);
    i_desc_wr = 1'b0;
    enable = 1'b1;
    exp_iss.push_back({2'd2, 8'h11});
    tick();
    check("consume_clear", o_desc_valid, 1'b0);
    i_desc_ready = 1'b0;
    i_resp_rd = 1'b1;
    resp(2'd2, 8'h11, 1'b1);
    wait_drain(10);
    check("ok_no_err", o_err_unexp_resp, 1'b0);

    // Round-robin over preloaded channels
    do_reset();
    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 2; n++) push(2'(c), 8'(8'h80 + c*16 + n), 1'b0);
    check("rr_preload_lvl", o_ch_level, {3'd2, 3'd2, 3'd2, 3'd1});
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < 4; c++) exp_iss.push_back({2'(c), 8'(8'h80 + c*16 + n)});
    i_desc_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt++;
      if (exp_iss.size() == 0) break;
    end
    check("rr_cycles", cnt, 8);

    // Outstanding limit stalls ch1 until a completion arrives
    do_reset();
    for (int n = 0; n < 8; n++) push(2'd1, 8'(8'h40 + n), 1'b1);
    push(2'd1, 8'h48, 1'b0);
    push(2'd1, 8'h49, 1'b0);
    repeat (5) tick();
    check("stall_level", lvl(1), 3'd2);
    check("stall_valid", o_desc_valid, 1'b0);
    check("stall_drained", exp_iss.size(), 0);
    exp_iss.push_back({2'd1, 8'h48});
    resp(2'd1, 8'h40, 1'b1);
    repeat (5) tick();
    check("stall_one_more", lvl(1), 3'd1);
    wait_drain(5);

    // Completion with nothing outstanding
    i_resp_rd = 1'b0;
    check("unexp_pre", o_err_unexp_resp, 1'b0);
    resp(2'd3, 8'h33, 1'b0);
    check("unexp_err", o_err_unexp_resp, 1'b1);
    check("unexp_no_resp", o_resp_valid, 1'b0);
    repeat (3) tick();
    check("unexp_sticky", o_err_unexp_resp, 1'b1);
    i_resp_rd = 1'b1;

    // Full channel back-pressure and push/pop on the same FIFO
    i_desc_ready = 1'b0;
    for (int n = 0; n < 5; n++) push(2'd0, 8'(8'h60 + n), 1'b1);
    check("full_level", lvl(0), 3'd4);
    i_desc_ch_sel = 2'd0;
    #1;
    check("full_wready_ch0", o_desc_wready, 1'b0);
    i_desc_ch_sel = 2'd1;
    #1;
    check("full_wready_ch1", o_desc_wready, 1'b1);
    i_desc_wr = 1'b1;
    i_desc_ch_sel = 2'd0;
    i_desc_id = 8'h65;
    i_desc_data = mkdata(2'd0, 8'h65);
    i_desc_ready = 1'b1;
    #1;
    check("full_push_reject", o_desc_wready, 1'b0);
    tick();
    check("full_pop_level", lvl(0), 3'd3);
    check("full_wready_after", o_desc_wready, 1'b1);
    exp_iss.push_back({2'd0, 8'h65});
    tick();
    i_desc_wr = 1'b0;
    check("pushpop_level", lvl(0), 3'd3);
    wait_drain(12);
    check("full_drained_lvl", lvl(0), 3'd0);

    // Reset in the middle of traffic
    i_desc_ready = 1'b0;
    i_ch_enable = 4'b0111;
    push(2'd2, 8'h72, 1'b0);
    for (int n = 0; n < 3; n++) push(2'd3, 8'(8'hB8 + n), 1'b0);
    tick();
    check("mid_pre_valid", o_desc_valid, 1'b1);
    check("mid_pre_lvl3", lvl(3), 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_level", o_ch_level, 12'd0);
    check("mid_rst_valid", o_desc_valid, 1'b0);
    check("mid_rst_err", o_err_unexp_resp, 1'b0);
    check("mid_rst_desc", {o_desc_ch_sel, o_desc_id, o_desc_data}, '0);
    tick();
    reset = 1'b0;
    i_ch_enable = 4'h0;
    push(2'd3, 8'h73, 1'b0);
    push(2'd0, 8'h70, 1'b0);
    exp_iss.push_back({2'd0, 8'h70});
    exp_iss.push_back({2'd3, 8'h73});
    i_ch_enable = 4'hF;
    i_desc_ready = 1'b1;
    wait_drain(10);
    resp(2'd1, 8'h49, 1'b0);
    check("mid_outst_cleared", o_err_unexp_resp, 1'b1);
    resp(2'd0, 8'h70, 1'b1);
    wait_drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
